fetch_sequencer: RTL and testbench

- Instruction-fetch stage between program_counter and the execute/decode logic of the 8085 core.
- Drives the PC's read-enable and increment controls and captures opcode and operand bytes from data_bus.
- Decodes 8085 instruction length (1/2/3 bytes) and presents a complete instruction to execute through a valid/ready handshake.

---
 rtl/fetch_sequencer.sv | 143 ++++++++++++++
 tb/tb_fetch_sequencer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// 8085 instruction-fetch sequencer: drives PC read/increment, collects opcode and
// operand bytes, decodes instruction length and hands the instruction to execute.
module fetch_sequencer #(
  parameter int unsigned WAIT_LIMIT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  data_bus,
  input  logic        mem_ready,
  output logic        pc_en_read,
  output logic        mem_rd,
  output logic        pc_inc,
  output logic [7:0]  ir_opcode,
  output logic [15:0] ir_operand,
  output logic [1:0]  ir_len,
  output logic        ir_valid,
  input  logic        ex_ready,
  input  logic        flush,
  output logic        fetch_err
);

  localparam int unsigned CNT_W = 8;

  localparam logic [2:0] F_OP = 3'd0;
  localparam logic [2:0] F_LO = 3'd1;
  localparam logic [2:0] F_HI = 3'd2;
  localparam logic [2:0] HOLD = 3'd3;
  localparam logic [2:0] ERR  = 3'd4;

  logic [2:0]       state, state_nxt;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic             valid_nxt, err_nxt;
  logic             cap_op, cap_lo, cap_hi;
  logic             fetching;
  logic [1:0]       len_dec;

  // 8085 instruction length from the opcode byte; undocumented codes are 1 byte
  function automatic logic [1:0] decode_len(input logic [7:0] op);
    logic [1:0] len;
    len = 2'd1;
    if ((op[7:6] == 2'b00 && op[3:0] == 4'h1) ||
        (op inside {8'h22, 8'h2A, 8'h32, 8'h3A, 8'hC3, 8'hCD}) ||
        (op[7:6] == 2'b11 && op[2:0] == 3'b010) ||
        (op[7:6] == 2'b11 && op[2:0] == 3'b100))
      len = 2'd3;
    else if ((op[7:6] == 2'b00 && op[2:0] == 3'b110) ||
             (op inside {8'hC6, 8'hCE, 8'hD6, 8'hDE, 8'hE6, 8'hEE, 8'hF6, 8'hFE,
                         8'hD3, 8'hDB}))
      len = 2'd2;
    return len;
  endfunction

  assign len_dec = decode_len(data_bus);

  // Bus controls decode from state; gated by reset so everything is 0 while held
  assign fetching   = reset && (state == F_OP || state == F_LO || state == F_HI);
  assign pc_en_read = fetching;
  assign mem_rd     = fetching;
  assign pc_inc     = fetching && mem_ready && !flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= F_OP;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    valid_nxt    = ir_valid;
    err_nxt      = fetch_err;
    cap_op       = 1'b0;
    cap_lo       = 1'b0;
    cap_hi       = 1'b0;
    if (flush) begin
      state_nxt    = F_OP;
      wait_cnt_nxt = '0;
      valid_nxt    = 1'b0;
      err_nxt      = 1'b0;
    end else begin
      case (state)
        F_OP, F_LO, F_HI: begin
          if (mem_ready) begin
            wait_cnt_nxt = '0;
            if (state == F_OP) begin
              cap_op    = 1'b1;
              state_nxt = (len_dec == 2'd1) ? HOLD : F_LO;
              valid_nxt = (len_dec == 2'd1);
            end else if (state == F_LO) begin
              cap_lo    = 1'b1;
              state_nxt = (ir_len == 2'd2) ? HOLD : F_HI;
              valid_nxt = (ir_len == 2'd2);
            end else begin
              cap_hi    = 1'b1;
              state_nxt = HOLD;
              valid_nxt = 1'b1;
            end
          end else if (wait_cnt == CNT_W'(WAIT_LIMIT - 1)) begin
            state_nxt    = ERR;
            err_nxt      = 1'b1;
            wait_cnt_nxt = '0;
          end else begin
            wait_cnt_nxt = wait_cnt + CNT_W'(1);
          end
        end
        HOLD: begin
          if (ex_ready) begin
            state_nxt = F_OP;
            valid_nxt = 1'b0;
          end
        end
        ERR:     state_nxt = ERR;
        default: state_nxt = F_OP;
      endcase
    end
  end

  // Instruction register and status flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ir_opcode  <= 8'h00;
      ir_operand <= 16'h0000;
      ir_len     <= 2'd0;
      ir_valid   <= 1'b0;
      fetch_err  <= 1'b0;
      wait_cnt   <= '0;
    end else begin
      ir_valid  <= valid_nxt;
      fetch_err <= err_nxt;
      wait_cnt  <= wait_cnt_nxt;
      if (cap_op) begin
        ir_opcode  <= data_bus;
        ir_operand <= 16'h0000;
        ir_len     <= len_dec;
      end
      if (cap_lo) ir_operand[7:0]  <= data_bus;
      if (cap_hi) ir_operand[15:8] <= data_bus;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer (WAIT_LIMIT=3) with hand-computed expectations.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  data_bus = 8'h00;
  logic        mem_ready = 1'b0;
  logic        ex_ready = 1'b0;
  logic        flush = 1'b0;
  logic        pc_en_read, mem_rd, pc_inc, ir_valid, fetch_err;
  logic [7:0]  ir_opcode;
  logic [15:0] ir_operand;
  logic [1:0]  ir_len;

  int checks = 0;
  int errors = 0;
  int inc_cnt = 0;
  int base;

  fetch_sequencer #(.WAIT_LIMIT(3)) dut (
    .clk(clk), .reset(reset), .data_bus(data_bus), .mem_ready(mem_ready),
    .pc_en_read(pc_en_read), .mem_rd(mem_rd), .pc_inc(pc_inc),
    .ir_opcode(ir_opcode), .ir_operand(ir_operand), .ir_len(ir_len),
    .ir_valid(ir_valid), .ex_ready(ex_ready), .flush(flush), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (pc_inc) inc_cnt <= inc_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_en_read"}, 32'(pc_en_read), 0);
    check({tag, "_mem_rd"},  32'(mem_rd), 0);
    check({tag, "_pc_inc"},  32'(pc_inc), 0);
    check({tag, "_opcode"},  32'(ir_opcode), 0);
    check({tag, "_operand"}, 32'(ir_operand), 0);
    check({tag, "_len"},     32'(ir_len), 0);
    check({tag, "_valid"},   32'(ir_valid), 0);
    check({tag, "_err"},     32'(fetch_err), 0);
  endtask

  logic [7:0] tbl_op  [10] = '{8'h01, 8'h08, 8'hCB, 8'hDD, 8'hC2, 8'hFC, 8'hFE, 8'hDB, 8'h36, 8'h76};
  logic [1:0] tbl_len [10] = '{2'd3,  2'd1,  2'd1,  2'd1,  2'd3,  2'd3,  2'd2,  2'd2,  2'd2,  2'd1};

  initial begin
    #1 reset = 1'b0;
    step(); step();
    check_all_zero("in_reset");

    // 1-byte MOV A,B straight out of reset
    data_bus = 8'h78; mem_ready = 1'b1; ex_ready = 1'b1; reset = 1'b1;
    #1 check("t1_pc_inc", 32'(pc_inc), 1);
    check("t1_mem_rd", 32'(mem_rd), 1);
    base = inc_cnt;
    step();
    check("t1_valid", 32'(ir_valid), 1);
    check("t1_opcode", 32'(ir_opcode), 32'h78);
    check("t1_len", 32'(ir_len), 1);
    check("t1_operand", 32'(ir_operand), 0);
    check("t1_hold_rd", 32'(mem_rd), 0);
    check("t1_incs", 32'(inc_cnt - base), 1);
    mem_ready = 1'b0;
    step();
    check("t1_valid_drop", 32'(ir_valid), 0);
    check("t1_refetch", 32'(pc_en_read), 1);

    // JMP 1234 with two wait cycles before the low byte
    data_bus = 8'hC3; mem_ready = 1'b1; ex_ready = 1'b0; base = inc_cnt;
    step();
    mem_ready = 1'b0; data_bus = 8'hEE;
    #1 check("t2_wait_inc", 32'(pc_inc), 0);
    check("t2_wait_rd", 32'(mem_rd), 1);
    step(); step();
    check("t2_no_err", 32'(fetch_err), 0);
    data_bus = 8'h34; mem_ready = 1'b1;
    step();
    data_bus = 8'h12;
    check("t2_not_yet", 32'(ir_valid), 0);
    step();
    check("t2_valid", 32'(ir_valid), 1);
    check("t2_opcode", 32'(ir_opcode), 32'hC3);
    check("t2_len", 32'(ir_len), 3);
    check("t2_operand", 32'(ir_operand), 32'h1234);
    check("t2_incs", 32'(inc_cnt - base), 3);
    ex_ready = 1'b1; mem_ready = 1'b0;
    step();
    check("t2_accept", 32'(ir_valid), 0);

    // MVI A,5A held for five cycles of back-pressure
    data_bus = 8'h3E; mem_ready = 1'b1; ex_ready = 1'b0; base = inc_cnt;
    step();
    data_bus = 8'h5A;
    step();
    data_bus = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      check("t3_hold_valid", 32'(ir_valid), 1);
      check("t3_hold_inc", 32'(pc_inc), 0);
      check("t3_hold_operand", 32'(ir_operand), 32'h005A);
      step();
    end
    check("t3_opcode", 32'(ir_opcode), 32'h3E);
    check("t3_len", 32'(ir_len), 2);
    check("t3_incs", 32'(inc_cnt - base), 2);
    ex_ready = 1'b1;
    step();
    check("t3_accept", 32'(ir_valid), 0);

    // CALL abandoned by flush during the low-byte fetch
    data_bus = 8'hCD; mem_ready = 1'b1; ex_ready = 1'b0; base = inc_cnt;
    step();
    data_bus = 8'h11; flush = 1'b1;
    #1 check("t4_flush_inc", 32'(pc_inc), 0);
    step();
    flush = 1'b0;
    check("t4_valid", 32'(ir_valid), 0);
    check("t4_incs", 32'(inc_cnt - base), 1);
    check("t4_old_opcode", 32'(ir_opcode), 32'hCD);
    check("t4_old_operand", 32'(ir_operand), 0);
    data_bus = 8'h78; ex_ready = 1'b1;
    #1 check("t4_refetch_inc", 32'(pc_inc), 1);
    step();
    check("t4_new_opcode", 32'(ir_opcode), 32'h78);
    check("t4_new_valid", 32'(ir_valid), 1);
    mem_ready = 1'b0;
    step();

    // Timeout after three wait cycles, cleared by flush
    step(); step();
    check("t5_err_early", 32'(fetch_err), 0);
    step();
    check("t5_err", 32'(fetch_err), 1);
    check("t5_err_rd", 32'(mem_rd), 0);
    check("t5_err_en", 32'(pc_en_read), 0);
    mem_ready = 1'b1;
    #1 check("t5_err_inc", 32'(pc_inc), 0);
    step();
    check("t5_err_sticky", 32'(fetch_err), 1);
    flush = 1'b1;
    step();
    flush = 1'b0; data_bus = 8'h00; ex_ready = 1'b1;
    check("t5_cleared", 32'(fetch_err), 0);
    check("t5_restart_rd", 32'(mem_rd), 1);
    step();
    check("t5_nop_valid", 32'(ir_valid), 1);
    check("t5_nop_len", 32'(ir_len), 1);
    step();

    // Length decode across a spread of opcodes
    for (int i = 0; i < 10; i++) begin
      data_bus = tbl_op[i]; mem_ready = 1'b1; ex_ready = 1'b1;
      step();
      check($sformatf("len_%02h", tbl_op[i]), 32'(ir_len), 32'(tbl_len[i]));
      data_bus = 8'h00;
      for (int k = 1; k < int'(tbl_len[i]); k++) step();
      check($sformatf("valid_%02h", tbl_op[i]), 32'(ir_valid), 1);
      step();
    end

    // Reset dropped during the high-byte fetch of LXI H
    data_bus = 8'h21; mem_ready = 1'b1; ex_ready = 1'b0; base = inc_cnt;
    step();
    data_bus = 8'h34;
    step();
    data_bus = 8'h12;
    reset = 1'b0;
    #1 check_all_zero("mid_reset");
    step(); step();
    check("t6_incs", 32'(inc_cnt - base), 2);
    mem_ready = 1'b0; reset = 1'b1;
    #1 check("t6_len_zero", 32'(ir_len), 0);
    check("t6_restart_en", 32'(pc_en_read), 1);
    data_bus = 8'h06; mem_ready = 1'b1;
    step();
    check("t6_new_len", 32'(ir_len), 2);
    check("t6_new_opcode", 32'(ir_opcode), 32'h06);
    check("t6_new_valid", 32'(ir_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
